// File: rtl/traffic_phase_sequencer.sv
// Phase sequencer for a main/side road intersection with a pedestrian crossing.
// All timing advances on the tick enable; request latches sample every clk.
module traffic_phase_sequencer #(
  parameter int CNT_W          = 8,
  parameter int MAIN_MIN_TICKS = 50,
  parameter int YELLOW_TICKS   = 30,
  parameter int ALLRED_TICKS   = 10,
  parameter int SIDE_TICKS     = 40
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       side_req,
  input  logic       ped_req,
  input  logic       night_mode,
  output logic [2:0] main_rgy,
  output logic [2:0] side_rgy,
  output logic       ped_walk,
  output logic       ped_ack,
  output logic [2:0] state_o
);

  localparam logic [2:0] S_MAIN_G   = 3'd0;
  localparam logic [2:0] S_MAIN_Y   = 3'd1;
  localparam logic [2:0] S_ALLRED_A = 3'd2;
  localparam logic [2:0] S_SIDE_G   = 3'd3;
  localparam logic [2:0] S_SIDE_Y   = 3'd4;
  localparam logic [2:0] S_ALLRED_B = 3'd5;
  localparam logic [2:0] S_FLASH    = 3'd6;

  localparam logic [CNT_W-1:0] MAIN_LAST   = CNT_W'(MAIN_MIN_TICKS - 1);
  localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_TICKS - 1);
  localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALLRED_TICKS - 1);
  localparam logic [CNT_W-1:0] SIDE_LAST   = CNT_W'(SIDE_TICKS - 1);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             side_pend_q, side_pend_d;
  logic             ped_pend_q, ped_pend_d;
  logic             flash_ph_q, flash_ph_d;
  logic             walk_q, walk_d;
  logic             ack_q, ack_d;
  logic             enter_side;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    flash_ph_d = flash_ph_q;
    walk_d     = walk_q;
    ack_d      = 1'b0;
    if (tick) begin
      case (state_q)
        S_MAIN_G: begin
          // Counter saturates here so a late request is served on the very next tick.
          if (cnt_q == MAIN_LAST) begin
            if (side_pend_q || ped_pend_q || night_mode) begin
              state_d = S_MAIN_Y;
              cnt_d   = '0;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_MAIN_Y: begin
          if (cnt_q == YELLOW_LAST) begin
            state_d = S_ALLRED_A;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_ALLRED_A: begin
          if (cnt_q == ALLRED_LAST) begin
            cnt_d = '0;
            if (night_mode) begin
              state_d    = S_FLASH;
              flash_ph_d = 1'b1;
            end else begin
              state_d = S_SIDE_G;
              walk_d  = ped_pend_q;
              ack_d   = ped_pend_q;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_SIDE_G: begin
          if (cnt_q == SIDE_LAST) begin
            state_d = S_SIDE_Y;
            cnt_d   = '0;
            walk_d  = 1'b0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_SIDE_Y: begin
          if (cnt_q == YELLOW_LAST) begin
            state_d = S_ALLRED_B;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_ALLRED_B: begin
          if (cnt_q == ALLRED_LAST) begin
            state_d = S_MAIN_G;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_FLASH: begin
          flash_ph_d = ~flash_ph_q;
          if (!night_mode) begin
            state_d = S_ALLRED_B;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = S_MAIN_G;
          cnt_d   = '0;
          walk_d  = 1'b0;
        end
      endcase
    end
  end

  // Grant edge clears the latches even if the input is still high on that edge.
  assign enter_side  = (state_d == S_SIDE_G) && (state_q != S_SIDE_G);
  assign side_pend_d = (enter_side || state_q == S_FLASH) ? 1'b0 : (side_pend_q | side_req);
  assign ped_pend_d  = (enter_side || state_q == S_FLASH) ? 1'b0 : (ped_pend_q | ped_req);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_MAIN_G;
      cnt_q       <= '0;
      side_pend_q <= 1'b0;
      ped_pend_q  <= 1'b0;
      flash_ph_q  <= 1'b0;
      walk_q      <= 1'b0;
      ack_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      side_pend_q <= side_pend_d;
      ped_pend_q  <= ped_pend_d;
      flash_ph_q  <= flash_ph_d;
      walk_q      <= walk_d;
      ack_q       <= ack_d;
    end
  end

  always_comb begin
    main_rgy = 3'b100;
    side_rgy = 3'b100;
    case (state_q)
      S_MAIN_G: main_rgy = 3'b001;
      S_MAIN_Y: main_rgy = 3'b010;
      S_SIDE_G: side_rgy = 3'b001;
      S_SIDE_Y: side_rgy = 3'b010;
      S_FLASH: begin
        main_rgy = flash_ph_q ? 3'b010 : 3'b000;
        side_rgy = flash_ph_q ? 3'b100 : 3'b000;
      end
      default: ;
    endcase
  end

  assign ped_walk = walk_q;
  assign ped_ack  = ack_q;
  assign state_o  = state_q;

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Directed bench for traffic_phase_sequencer with short phase durations.
// Each tick is followed by two idle clocks; outputs are sampled on the falling edge.
module tb_traffic_phase_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic       side_req = 1'b0;
  logic       ped_req = 1'b0;
  logic       night_mode = 1'b0;
  logic [2:0] main_rgy, side_rgy, state_o;
  logic       ped_walk, ped_ack;

  int checks = 0;
  int failures = 0;
  int ack_cnt = 0;
  int ack_base;
  logic side_hold = 1'b0;
  logic ped_hold = 1'b0;
  logic ack_after;

  // Entry layout: {flash_ph, ack, walk, state[2:0]}
  logic [5:0] exp_q[$];

  traffic_phase_sequencer #(
    .CNT_W(8), .MAIN_MIN_TICKS(4), .YELLOW_TICKS(2), .ALLRED_TICKS(1), .SIDE_TICKS(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .side_req(side_req), .ped_req(ped_req),
    .night_mode(night_mode), .main_rgy(main_rgy), .side_rgy(side_rgy),
    .ped_walk(ped_walk), .ped_ack(ped_ack), .state_o(state_o)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  always @(negedge clk) if (ped_ack) ack_cnt++;

  function automatic logic [5:0] lamps(input logic [2:0] s, input logic ph);
    case (s)
      3'd0: lamps = {3'b001, 3'b100};
      3'd1: lamps = {3'b010, 3'b100};
      3'd3: lamps = {3'b100, 3'b001};
      3'd4: lamps = {3'b100, 3'b010};
      3'd6: lamps = ph ? {3'b010, 3'b100} : {3'b000, 3'b000};
      default: lamps = {3'b100, 3'b100};
    endcase
  endfunction

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic push_n(input logic [2:0] s, input logic w, input logic a, input logic ph,
                        input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({ph, a, w, s});
  endtask

  // Driver tasks
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; tick = 1'b0; night_mode = 1'b0;
    side_hold = 1'b0; ped_hold = 1'b0; side_req = 1'b0; ped_req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
  endtask

  task automatic tick_once(input logic ps, input logic pp);
    side_req = side_hold | ps;
    ped_req  = ped_hold | pp;
    tick = 1'b1;
    @(negedge clk);
    ack_after = ped_ack;
    tick = 1'b0;
    side_req = side_hold;
    ped_req  = ped_hold;
    repeat (2) @(negedge clk);
  endtask

  task automatic step(input string tag, input logic ps, input logic pp);
    logic [5:0] e;
    tick_once(ps, pp);
    e = exp_q.pop_front();
    check_eq({tag, "_state"}, {5'd0, state_o}, {5'd0, e[2:0]});
    check_eq({tag, "_lamps"}, {2'd0, main_rgy, side_rgy}, {2'd0, lamps(e[2:0], e[5])});
    check_eq({tag, "_walk"}, {7'd0, ped_walk}, {7'd0, e[3]});
    check_eq({tag, "_ack"}, {7'd0, ack_after}, {7'd0, e[4]});
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_state"}, {5'd0, state_o}, 8'd0);
    check_eq({tag, "_main"}, {5'd0, main_rgy}, 8'b001);
    check_eq({tag, "_side"}, {5'd0, side_rgy}, 8'b100);
    check_eq({tag, "_walk"}, {7'd0, ped_walk}, 8'd0);
    check_eq({tag, "_ack"}, {7'd0, ped_ack}, 8'd0);
  endtask

  // Standard side phase for a request latched before tick 4; walk/ack reflect ped grant.
  task automatic push_side_cycle(input logic ped);
    push_n(3'd0, 1'b0, 1'b0, 1'b0, 3);
    push_n(3'd1, 1'b0, 1'b0, 1'b0, 2);
    push_n(3'd2, 1'b0, 1'b0, 1'b0, 1);
    push_n(3'd3, ped, ped, 1'b0, 1);
    push_n(3'd3, ped, 1'b0, 1'b0, 2);
    push_n(3'd4, 1'b0, 1'b0, 1'b0, 2);
    push_n(3'd5, 1'b0, 1'b0, 1'b0, 1);
    push_n(3'd0, 1'b0, 1'b0, 1'b0, 1);
  endtask

  initial begin
    // Test 1: idle, no requests
    do_reset();
    check_reset_outputs("t1_reset");
    push_n(3'd0, 1'b0, 1'b0, 1'b0, 50);
    for (int i = 0; i < 50; i++) step("t1_idle", 1'b0, 1'b0);

    // Test 2: side pulse at tick 1
    do_reset();
    push_side_cycle(1'b0);
    step("t2", 1'b1, 1'b0);
    for (int i = 2; i <= 13; i++) step("t2", 1'b0, 1'b0);

    // Test 3: ped pulse at tick 2, then nothing pending afterwards
    do_reset();
    ack_base = ack_cnt;
    push_side_cycle(1'b1);
    push_n(3'd0, 1'b0, 1'b0, 1'b0, 6);
    step("t3", 1'b0, 1'b0);
    step("t3", 1'b0, 1'b1);
    for (int i = 3; i <= 19; i++) step("t3", 1'b0, 1'b0);
    check_eq("t3_ack_pulses", 8'(ack_cnt - ack_base), 8'd1);

    // Test 4: side_req held through SIDE_G entry re-latches
    do_reset();
    side_hold = 1'b1;
    push_side_cycle(1'b0);
    push_n(3'd0, 1'b0, 1'b0, 1'b0, 3);
    push_n(3'd1, 1'b0, 1'b0, 1'b0, 2);
    push_n(3'd2, 1'b0, 1'b0, 1'b0, 1);
    push_n(3'd3, 1'b0, 1'b0, 1'b0, 1);
    for (int i = 1; i <= 8; i++) step("t4", 1'b0, 1'b0);
    side_hold = 1'b0;
    side_req = 1'b0;
    for (int i = 9; i <= 20; i++) step("t4", 1'b0, 1'b0);

    // Test 5: night mode beats a side request; ped press in FLASH is dropped
    do_reset();
    night_mode = 1'b1;
    push_n(3'd0, 1'b0, 1'b0, 1'b0, 3);
    push_n(3'd1, 1'b0, 1'b0, 1'b0, 2);
    push_n(3'd2, 1'b0, 1'b0, 1'b0, 1);
    push_n(3'd6, 1'b0, 1'b0, 1'b1, 1);
    push_n(3'd6, 1'b0, 1'b0, 1'b0, 1);
    push_n(3'd6, 1'b0, 1'b0, 1'b1, 1);
    push_n(3'd5, 1'b0, 1'b0, 1'b0, 1);
    push_n(3'd0, 1'b0, 1'b0, 1'b0, 7);
    step("t5", 1'b1, 1'b0);
    for (int i = 2; i <= 7; i++) step("t5", 1'b0, 1'b0);
    step("t5", 1'b0, 1'b1);
    step("t5", 1'b0, 1'b0);
    night_mode = 1'b0;
    for (int i = 10; i <= 17; i++) step("t5", 1'b0, 1'b0);

    // Test 6: asynchronous reset in the middle of a walk phase
    do_reset();
    push_n(3'd0, 1'b0, 1'b0, 1'b0, 3);
    push_n(3'd1, 1'b0, 1'b0, 1'b0, 2);
    push_n(3'd2, 1'b0, 1'b0, 1'b0, 1);
    push_n(3'd3, 1'b1, 1'b1, 1'b0, 1);
    push_n(3'd3, 1'b1, 1'b0, 1'b0, 1);
    step("t6", 1'b0, 1'b0);
    step("t6", 1'b0, 1'b1);
    for (int i = 3; i <= 8; i++) step("t6", 1'b0, 1'b0);
    ack_base = ack_cnt;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t6_async_rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    push_n(3'd0, 1'b0, 1'b0, 1'b0, 6);
    for (int i = 0; i < 6; i++) step("t6_after", 1'b0, 1'b0);
    check_eq("t6_no_ack", 8'(ack_cnt - ack_base), 8'd0);

    // Final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
